ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction prefetch buffer between the instruction memory and the rv32 core fetch stage.
- Drives the imem address with its own fetch PC and captures one word per cycle into a DEPTH-entry FIFO of {pc, instr} pairs.
- Presents the FIFO head to the core with a valid/ready handshake.
- Flushes and restarts on a core redirect (branch, jump, trap).

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- RESET_PC, 32'h00000000: fetch PC loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- mem_addr  output  32  imem byte address; always equals fetch PC (fpc).
- mem_rdata  input  32  imem word at mem_addr, combinational read within the same cycle.
- mem_ready  input  1  imem data valid this cycle; tied to 1 for the on-chip imem.
- redirect  input  1  core requests a flush and restart.
- redirect_pc  input  32  new fetch address, sampled when redirect=1.
- out_valid  output  1  head entry is valid.
- out_instr  output  32  head instruction.
- out_pc  output  32  PC of the head instruction.
- out_ready  input  1  core consumes the head this cycle.
- count  output  log2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - fpc=RESET_PC, read pointer=0, write pointer=0, count=0.
  - out_valid=0, out_instr=0, out_pc=0.
  - Asserting reset mid-operation discards all entries at once.
- Control signals:
  - pop = out_valid & out_ready.
  - push = mem_ready & ~redirect & (count<DEPTH | pop). A full queue accepts a push in the same cycle as a pop.
- Push: the entry at the write pointer gets {fpc, mem_rdata}. The write pointer advances modulo DEPTH. fpc <= fpc+4, wrapping modulo 2^32 (32'hFFFFFFFC+4 = 0).
- Pop: the read pointer advances modulo DEPTH.
- count update: next count = count + push - pop. Simultaneous push and pop leaves count unchanged.
- Output path:
  - out_valid = (count!=0).
  - out_instr and out_pc come from the head entry when count!=0, and are forced to 0 when count==0.
  - Outputs are driven from registers only, with no combinational path from mem_rdata.
- Redirect has the highest priority below reset. On the cycle redirect=1:
  - no push and no pop take effect, whatever out_ready is;
  - on the next edge count=0, both pointers=0, and fpc = {redirect_pc[31:2], 2'b00} (a misaligned target is force-aligned);
  - out_valid is 0 in the following cycle;
  - the first instruction from the new target appears in the cycle after that.
- Latency: a word presented at mem_addr in cycle N is at the head in cycle N+1 if the queue was empty. Steady throughput is 1 instruction per cycle when out_ready=1 and mem_ready=1.
- Full with no pop: fpc holds, no write happens, and mem_addr stays stable.
- mem_ready=0: no push and fpc holds. Pops continue normally.
- Empty with out_ready=1: pop=0, and no state change other than a possible push.
- Data integrity: entries leave in push order. No entry is duplicated or dropped unless a redirect or reset discards it.

Test Plan:
1. Reset release, RESET_PC=0, imem word at address a = a>>2, out_ready=1 -> out_valid rises one cycle after the first edge; out_pc sequence 0,4,8,12; out_instr 0,1,2,3; count stays 1.
2. out_ready=0 for 8 cycles after reset -> count climbs 1,2,3,4 and saturates at 4; mem_addr freezes at 16; out_pc stays 0. Then out_ready=1 -> pops 0,4,8,12,16 back-to-back with no bubble, and the full-queue push-while-pop keeps count at 4.
3. Queue holds pc 0..12, redirect=1 with redirect_pc=32'h100 and out_ready=1 -> no pop that cycle; out_valid=0 next cycle; next head has out_pc=32'h100; the old entries 0..12 never appear.
4. redirect_pc=32'h00000203 -> the fetch restarts at 32'h200; out_pc of the first new entry is 32'h200.
5. fpc near wrap: redirect to 32'hFFFFFFF8, out_ready=1 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
6. Queue at count=3, reset driven to 0 between clock edges -> count=0, out_valid=0 and mem_addr=RESET_PC immediately without waiting for an edge. After release, behaviour matches scenario 1.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction prefetch buffer: fetches one imem word per cycle into a small FIFO of
// {pc, instr} pairs and hands the head to the core with a valid/ready handshake.
module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [31:0]              mem_addr,
   input  logic [31:0]              mem_rdata,
   input  logic                     mem_ready,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   output logic                     out_valid,
   output logic [31:0]              out_instr,
   output logic [31:0]              out_pc,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   fpc;
   logic [31:0]   pc_mem    [DEPTH];
   logic [31:0]   instr_mem [DEPTH];
   logic [AW-1:0] rptr;
   logic [AW-1:0] wptr;
   logic [AW:0]   cnt;
   logic          full;
   logic          pop;
   logic          push;

   // A full queue may still accept a word when the head leaves in the same cycle.
   assign full = (cnt == (AW+1)'(DEPTH));
   assign pop  = out_valid & out_ready & ~redirect;
   assign push = mem_ready & ~redirect & (~full | pop);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fpc  <= RESET_PC;
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (redirect) begin
         fpc  <= {redirect_pc[31:2], 2'b00};
         rptr <= '0;
         wptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            pc_mem[wptr]    <= fpc;
            instr_mem[wptr] <= mem_rdata;
            wptr            <= wptr + AW'(1);
            fpc             <= fpc + 32'd4;
         end
         if (pop) begin
            rptr <= rptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Head is taken from storage registers only; an empty queue shows zeros.
   assign out_valid = (cnt != '0);
   assign out_pc    = out_valid ? pc_mem[rptr]    : '0;
   assign out_instr = out_valid ? instr_mem[rptr] : '0;
   assign mem_addr  = fpc;
   assign count     = cnt;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue; the imem model returns address>>2 as the word.
module tb_ifetch_queue;

   logic        clk;
   logic        reset;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready;
   logic [2:0]  count;

   int nChecks = 0;
   int nFails  = 0;

   ifetch_queue #(.DEPTH(4), .RESET_PC(32'h00000000)) dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .redirect(redirect), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
      .out_ready(out_ready), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem_addr >> 2;

   // Holds reset across an edge and releases it on a falling edge.
   task automatic applyStimulus(input logic rdy);
      reset     = 1'b0;
      redirect  = 1'b0;
      mem_ready = 1'b1;
      out_ready = rdy;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset;
      reset = 1'b0; redirect = 1'b0; redirect_pc = '0; mem_ready = 1'b1; out_ready = 1'b1;
      #3;
      nChecks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || mem_addr !== 32'h0 || out_pc !== 32'h0 || out_instr !== 32'h0) begin
         nFails++;
         $display("[TB] FAIL reset_state: valid=%b count=%0d addr=%h pc=%h instr=%h, want 0", out_valid, count, mem_addr, out_pc, out_instr);
      end
   endtask

   task automatic test_stream;
      applyStimulus(1'b1);
      nChecks++;
      if (out_valid !== 1'b0 || count !== 3'd0) begin
         nFails++;
         $display("[TB] FAIL stream_pre_edge: valid=%b count=%0d want 0/0", out_valid, count);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nChecks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4*i) || out_instr !== 32'(i) || count !== 3'd1 || mem_addr !== 32'(4*(i+1))) begin
            nFails++;
            $display("[TB] FAIL stream_%0d: valid=%b pc=%h instr=%h count=%0d addr=%h want 1/%h/%h/1/%h",
                     i, out_valid, out_pc, out_instr, count, mem_addr, 4*i, i, 4*(i+1));
         end
      end
   endtask

   task automatic test_fill_drain;
      int expCnt;
      applyStimulus(1'b0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         expCnt = (k < 4) ? k : 4;
         nChecks++;
         if (out_valid !== 1'b1 || count !== 3'(expCnt) || out_pc !== 32'h0 || mem_addr !== 32'(4*expCnt)) begin
            nFails++;
            $display("[TB] FAIL fill_%0d: valid=%b count=%0d pc=%h addr=%h want 1/%0d/0/%h",
                     k, out_valid, count, out_pc, mem_addr, expCnt, 4*expCnt);
         end
      end
      out_ready = 1'b1;
      for (int j = 0; j <= 4; j++) begin
         if (j > 0) @(negedge clk);
         nChecks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(4*j) || out_instr !== 32'(j) || count !== 3'd4) begin
            nFails++;
            $display("[TB] FAIL drain_%0d: valid=%b pc=%h instr=%h count=%0d want 1/%h/%h/4",
                     j, out_valid, out_pc, out_instr, count, 4*j, j);
         end
      end
   endtask

   task automatic test_redirect;
      applyStimulus(1'b0);
      repeat (4) @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
      @(negedge clk);
      redirect = 1'b0;
      nChecks++;
      if (out_valid !== 1'b0 || count !== 3'd0 || mem_addr !== 32'h100 || out_pc !== 32'h0) begin
         nFails++;
         $display("[TB] FAIL redirect_flush: valid=%b count=%0d addr=%h pc=%h want 0/0/100/0", out_valid, count, mem_addr, out_pc);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nChecks++;
         if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4*i) || out_instr !== 32'h40 + 32'(i)) begin
            nFails++;
            $display("[TB] FAIL redirect_new_%0d: valid=%b pc=%h instr=%h want 1/%h/%h",
                     i, out_valid, out_pc, out_instr, 32'h100 + 32'(4*i), 32'h40 + 32'(i));
         end
      end
   endtask

   task automatic test_misaligned;
      redirect = 1'b1; redirect_pc = 32'h00000203;
      @(negedge clk);
      redirect = 1'b0;
      nChecks++;
      if (out_valid !== 1'b0 || mem_addr !== 32'h200) begin
         nFails++;
         $display("[TB] FAIL misaligned_addr: valid=%b addr=%h want 0/200", out_valid, mem_addr);
      end
      @(negedge clk);
      nChecks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h200 || out_instr !== 32'h80) begin
         nFails++;
         $display("[TB] FAIL misaligned_head: valid=%b pc=%h instr=%h want 1/200/80", out_valid, out_pc, out_instr);
      end
   endtask

   task automatic test_wrap;
      logic [31:0] expPc [4];
      expPc[0] = 32'hFFFFFFF8; expPc[1] = 32'hFFFFFFFC; expPc[2] = 32'h0; expPc[3] = 32'h4;
      out_ready = 1'b1;
      redirect = 1'b1; redirect_pc = 32'hFFFFFFF8;
      @(negedge clk);
      redirect = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nChecks++;
         if (out_valid !== 1'b1 || out_pc !== expPc[i] || out_instr !== (expPc[i] >> 2)) begin
            nFails++;
            $display("[TB] FAIL wrap_%0d: valid=%b pc=%h instr=%h want 1/%h/%h",
                     i, out_valid, out_pc, out_instr, expPc[i], expPc[i] >> 2);
         end
      end
   endtask

   task automatic test_async_reset;
      applyStimulus(1'b0);
      repeat (3) @(negedge clk);
      nChecks++;
      if (count !== 3'd3) begin
         nFails++;
         $display("[TB] FAIL async_pre_count: count=%0d want 3", count);
      end
      #2 reset = 1'b0;
      #1;
      nChecks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || mem_addr !== 32'h0 || out_pc !== 32'h0) begin
         nFails++;
         $display("[TB] FAIL async_clear: count=%0d valid=%b addr=%h pc=%h want 0/0/0/0", count, out_valid, mem_addr, out_pc);
      end
      test_stream();
   endtask

   task automatic test_mem_stall;
      applyStimulus(1'b1);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nChecks++;
         if (out_valid !== 1'b0 || count !== 3'd0 || mem_addr !== 32'h0) begin
            nFails++;
            $display("[TB] FAIL stall_%0d: valid=%b count=%0d addr=%h want 0/0/0", i, out_valid, count, mem_addr);
         end
      end
      mem_ready = 1'b1;
      @(negedge clk);
      nChecks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || count !== 3'd1 || mem_addr !== 32'h4) begin
         nFails++;
         $display("[TB] FAIL stall_resume: valid=%b pc=%h count=%0d addr=%h want 1/0/1/4", out_valid, out_pc, count, mem_addr);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_fill_drain();
      test_redirect();
      test_misaligned();
      test_wrap();
      test_async_reset();
      test_mem_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
